seq_multiplier: RTL
===================

# seq_multiplier

Sequential unsigned shift-add multiplier for the arithmetic processor. It is the companion to the restoring divider, and the datapath issues multiply operations to it. Operands are captured on a start handshake. One partial product is retired per clock, and the full double-width product is presented with a one-cycle done strobe. The block iterates over multiplier bits with a counter and reports readiness to the issuing logic.

## Interface

**Parameters**
- `WIDTH`, default 8: operand width in bits. The product is 2×WIDTH bits.

**Ports**
- `clk` (in, 1): single clock; all state changes on its rising edge.
- `reset` (in, 1): synchronous, active-high reset.
- `start` (in, 1): request; sampled only while `ready`=1.
- `multiplicand` (in, WIDTH): operand A, unsigned; captured with `start`.
- `multiplier` (in, WIDTH): operand B, unsigned; captured with `start`.
- `product` (out, 2×WIDTH): registered result; holds until the next accepted start.
- `ready` (out, 1): high in IDLE only; block can accept `start`.
- `done` (out, 1): one-cycle strobe; `product` is valid in that cycle and after it.

## Operation

- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:** `ready`=1. On `start`=1:
  - capture A into `mcand` (WIDTH).
  - load `acc` (WIDTH+1, extra carry bit) with 0.
  - load `mplr` (WIDTH) with B.
  - load `count` with WIDTH.
  - go to BUSY.
- **BUSY, one step per cycle:**
  - sum = `acc` + (`mplr[0]` ? `mcand` : 0), computed in WIDTH+1 bits with no overflow loss.
  - {`acc`, `mplr`} ← {sum, `mplr`} >> 1 (logical).
  - `count` ← `count` − 1.
  - When `count` reaches 1 during a step, go to DONE and load `product` ← {`acc`[WIDTH-1:0], `mplr`} as updated by that final step.
- **DONE:** `done`=1 and `ready`=0 for exactly one cycle, then unconditionally go to IDLE.
- **Ignored `start`:** `start` in BUSY or DONE is ignored. It is not queued and operands do not change.
- **Arithmetic:** unsigned, exact: `product` = A × B mod 2^(2×WIDTH). No overflow is possible.
- **Counter width:** `count` is $clog2(WIDTH+1) bits.
- **Reset:** when `reset`=1 at a clock edge, in any state including mid-BUSY:
  - state ← IDLE.
  - `product`, `acc`, `mplr`, `mcand`, `count` ← 0.
  - `done` ← 0, `ready` ← 1 from the next cycle.
  - A `start` asserted in the same cycle as `reset` is discarded.
- **Reset values of outputs:** `product`=0, `ready`=1, `done`=0.

## Timing

- **Latency:** `start` is accepted at edge k. BUSY occupies cycles k+1 … k+WIDTH. DONE, with `done`=1 and `product` valid, is cycle k+WIDTH+1. `ready`=1 again in cycle k+WIDTH+2.
- **Throughput:** one operation per WIDTH+2 cycles. `start` held high continuously restarts on the first IDLE cycle.
- **Output registering:** `ready` and `done` decode registered state only; there is no combinational path from `start`. `product` is a register written only on the BUSY→DONE transition and by reset.
- **Operand stability:** operands are sampled only at the accepting edge. Changes afterwards have no effect.

## Structure

- **Shared package `arith_pkg`:**
  - state enum `mul_state_t` {IDLE, BUSY, DONE}.
  - default width constant `ARITH_WIDTH`=8, also used by the divider.
- **Sub-modules:** none needed. Datapath and FSM fit in one module; the (WIDTH+1)-bit add is inline.

## Test plan

- **Basic:** reset, then A=13, B=11, `start` for 1 cycle. Expect `done` at cycle 9 after acceptance, `product`=0x008F (143), `ready`=0 throughout.
- **Max operands:** A=255, B=255. Expect `product`=0xFE01 (65025); confirms the carry bit in `acc`.
- **Zero operands:** A=0, B=200, then A=200, B=0. Expect `product`=0 both times with full WIDTH+2-cycle timing.
- **Start while busy:** A=6, B=7 accepted. Pulse `start` with A=9, B=9 in BUSY cycle 3 and in the DONE cycle. Expect `product`=42 and only one `done`.
- **Reset mid-operation:** accept A=100, B=3; assert `reset` in BUSY cycle 4. Expect `product`=0, `done` never pulses, `ready`=1 the next cycle. A new A=100, B=3 then yields 300 (0x012C).
- **Back-to-back:** `start` held high, A=2, B=3. Expect `done` pulses every 10 cycles with `product`=6, and `product` held stable between strobes.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic processor's iterative units
// (shift-add multiplier and restoring divider).
package arith_pkg;

    // Default operand width shared by the multiplier and the divider
    localparam int ARITH_WIDTH = 8;

    // Multiplier control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage : arith_pkg

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier.
// Each BUSY cycle retires one multiplier bit. The double-width product is
// registered on the last step and is flagged by a one-cycle done strobe.
module seq_multiplier
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               ready,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   acc;      // carry bit on top keeps the add exact
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shifted;

    // Add the multiplicand when the current multiplier LSB is set, then
    // shift the {acc, mplr} pair right by one as a single register.
    assign sum     = acc + {1'b0, (mplr[0] ? mcand : '0)};
    assign shifted = {sum, mplr} >> 1;

    // Control FSM and datapath with registered ready/done outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            product <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplr    <= '0;
            count   <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= multiplicand;
                        acc   <= '0;
                        mplr  <= multiplier;
                        count <= CW'(WIDTH);
                        ready <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= shifted[2*WIDTH:WIDTH];
                    mplr  <= shifted[WIDTH-1:0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        // The final step's result is captured directly so
                        // product is valid in the DONE cycle itself.
                        product <= shifted[2*WIDTH-1:0];
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : seq_multiplier
